// File: rtl/cv32e40p_sleep_sequencer.sv
// WFI sleep sequencer: drains the pipeline, gates the core clock, reopens it on wake
// and retires the WFI after a settle period. Runs on the free-running clock.
module cv32e40p_sleep_sequencer #(
    parameter int WAKE_DELAY = 2,
    parameter int CNT_W      = 4
) (
    input  logic             clk_ungated_i,
    input  logic             rst_n,
    input  logic             fetch_enable_i,
    input  logic             wfi_req_i,
    input  logic             debug_no_sleep_i,
    input  logic             if_busy_i,
    input  logic             lsu_busy_i,
    input  logic             apu_busy_i,
    input  logic             wake_i,
    output logic             clock_en_o,
    output logic             core_sleep_o,
    output logic             wfi_ack_o,
    output logic             fetch_enable_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SLEEP = 3'd3,
        ST_WAKE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LP_WAKE_LOAD =
        (WAKE_DELAY > 0) ? CNT_W'(WAKE_DELAY - 1) : '0;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_fetch_en;
    logic               w_fetch_en_next;
    logic               r_wfi_ack;
    logic               w_ack_next;
    logic               w_any_busy;
    logic               w_clock_en;

    assign w_any_busy = if_busy_i | lsu_busy_i | apu_busy_i;

    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RESET;
            r_cnt      <= '0;
            r_fetch_en <= 1'b0;
            r_wfi_ack  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_fetch_en <= w_fetch_en_next;
            r_wfi_ack  <= w_ack_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_ack_next      = 1'b0;
        w_fetch_en_next = r_fetch_en | fetch_enable_i;
        case (r_state)
            ST_RESET: begin
                if (w_fetch_en_next) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                // A WFI under a debug condition retires immediately as a NOP.
                if (wfi_req_i && !debug_no_sleep_i) w_state_next = ST_DRAIN;
                else if (wfi_req_i)                 w_ack_next   = 1'b1;
            end
            ST_DRAIN: begin
                if (wake_i || debug_no_sleep_i) begin
                    w_state_next = ST_RUN;
                    w_ack_next   = 1'b1;
                end else if (!w_any_busy) begin
                    w_state_next = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (wake_i) begin
                    if (WAKE_DELAY == 0) begin
                        w_state_next = ST_RUN;
                        w_ack_next   = 1'b1;
                    end else begin
                        w_state_next = ST_WAKE;
                        w_cnt_next   = LP_WAKE_LOAD;
                    end
                end
            end
            ST_WAKE: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_RUN;
                    w_ack_next   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_next = ST_RESET;
        endcase
    end

    always_comb begin
        w_clock_en   = 1'b0;
        core_sleep_o = 1'b0;
        case (r_state)
            ST_RESET: w_clock_en = fetch_enable_i | r_fetch_en;
            ST_RUN,
            ST_DRAIN,
            ST_WAKE:  w_clock_en = 1'b1;
            ST_SLEEP: begin
                w_clock_en   = wake_i;
                core_sleep_o = !wake_i;
            end
            default:  w_clock_en = 1'b0;
        endcase
        // The gate must close the instant reset is applied, whatever fetch_enable_i does.
        clock_en_o = w_clock_en & rst_n;
    end

    assign wfi_ack_o      = r_wfi_ack;
    assign fetch_enable_o = r_fetch_en;
    assign state_o        = r_state;

    a_no_busy_in_sleep: assert property (@(posedge clk_ungated_i) disable iff (!rst_n)
        (r_state == ST_SLEEP) |-> !w_any_busy);

    a_sleep_gated: assert property (@(posedge clk_ungated_i) disable iff (!rst_n)
        core_sleep_o |-> !clock_en_o);

    a_sleep_frozen: assert property (@(posedge clk_ungated_i) disable iff (!rst_n)
        core_sleep_o |-> (w_state_next == r_state && w_cnt_next == r_cnt &&
                          w_fetch_en_next == r_fetch_en && w_ack_next == r_wfi_ack));

    a_ack_single: assert property (@(posedge clk_ungated_i) disable iff (!rst_n)
        wfi_ack_o |=> !wfi_ack_o);

endmodule
